// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: command codes per MODE,
// operand-valid encodings, result flag bundle and rotate-field sizing.
package alu_pkg;

    // Default operand width; the rotate field is log2 of the operand width.
    localparam int ALU_WIDTH_DEF = 4;

    // Number of OPB bits that form the rotate amount for a given operand width.
    function automatic int rot_field_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int ROT_W = rot_field_w(ALU_WIDTH_DEF);

    // Arithmetic command set (MODE = 1)
    localparam logic [3:0] ARITH_ADD     = 4'd0;
    localparam logic [3:0] ARITH_SUB     = 4'd1;
    localparam logic [3:0] ARITH_ADD_CIN = 4'd2;
    localparam logic [3:0] ARITH_SUB_CIN = 4'd3;
    localparam logic [3:0] ARITH_INC_A   = 4'd4;
    localparam logic [3:0] ARITH_DEC_A   = 4'd5;
    localparam logic [3:0] ARITH_INC_B   = 4'd6;
    localparam logic [3:0] ARITH_DEC_B   = 4'd7;
    localparam logic [3:0] ARITH_CMP     = 4'd8;
    localparam logic [3:0] ARITH_MUL_INC = 4'd9;
    localparam logic [3:0] ARITH_MUL_SHL = 4'd10;
    localparam logic [3:0] ARITH_SADD    = 4'd11;
    localparam logic [3:0] ARITH_SSUB    = 4'd12;

    // Logical command set (MODE = 0)
    localparam logic [3:0] LOGIC_AND     = 4'd0;
    localparam logic [3:0] LOGIC_NAND    = 4'd1;
    localparam logic [3:0] LOGIC_OR      = 4'd2;
    localparam logic [3:0] LOGIC_NOR     = 4'd3;
    localparam logic [3:0] LOGIC_XOR     = 4'd4;
    localparam logic [3:0] LOGIC_XNOR    = 4'd5;
    localparam logic [3:0] LOGIC_NOT_A   = 4'd6;
    localparam logic [3:0] LOGIC_NOT_B   = 4'd7;
    localparam logic [3:0] LOGIC_SHR1_A  = 4'd8;
    localparam logic [3:0] LOGIC_SHL1_A  = 4'd9;
    localparam logic [3:0] LOGIC_SHR1_B  = 4'd10;
    localparam logic [3:0] LOGIC_SHL1_B  = 4'd11;
    localparam logic [3:0] LOGIC_ROL_A_B = 4'd12;
    localparam logic [3:0] LOGIC_ROR_A_B = 4'd13;

    // INP_VALID encodings: bit0 = OPA valid, bit1 = OPB valid
    localparam logic [1:0] VLD_NONE = 2'b00;
    localparam logic [1:0] VLD_A    = 2'b01;
    localparam logic [1:0] VLD_B    = 2'b10;
    localparam logic [1:0] VLD_AB   = 2'b11;

    // Status flags that travel alongside RES
    typedef struct packed {
        logic cout;
        logic oflow;
        logic g;
        logic e;
        logic l;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_compute.sv
// Combinational ALU core: maps one registered command and its operands to
// the next RES value and flag set. Fault cases (undefined command, missing
// operand, out-of-range rotate) force RES to zero with only ERR raised.
module alu_compute
    import alu_pkg::*;
#(
    parameter int width     = 4,
    parameter int CMD_WIDTH = 4
) (
    input  logic                 mode_i,
    input  logic [CMD_WIDTH-1:0] cmd_i,
    input  logic [1:0]           inp_valid_i,
    input  logic [width-1:0]     opa_i,
    input  logic [width-1:0]     opb_i,
    input  logic                 cin_i,
    output logic [2*width-1:0]   res_o,
    output alu_flags_t           flags_o,
    output logic                 is_mul_o
);

    localparam int RW = rot_field_w(width);
    localparam int W2 = 2 * width;

    logic [3:0]       cmd_lo_s;
    logic             cmd_hi_s;
    logic [width:0]   ax_s;
    logic [width:0]   bx_s;
    logic [width:0]   sax_s;
    logic [width:0]   sbx_s;
    logic [width:0]   one_x_s;
    logic [width:0]   cin_x_s;
    logic [width:0]   tmp_s;
    logic [width-1:0] shl_a_s;
    logic [width-1:0] rol_s;
    logic [width-1:0] ror_s;
    logic [width-1:0] lres_s;
    logic [RW-1:0]    amt_s;
    logic             rot_bad_s;
    logic             rot_cmd_s;
    logic             defined_s;
    logic [1:0]       need_s;
    logic             fault_s;
    logic [W2-1:0]    res_raw_s;
    alu_flags_t       flags_raw_s;

    // Split the command into its 4-bit code and any extra upper bits,
    // which make the command undefined when set.
    assign cmd_lo_s = 4'(cmd_i);
    assign cmd_hi_s = (cmd_i >> 4) != '0;

    // Multiplies take the extra pipeline stage in the top level.
    assign is_mul_o = mode_i && !cmd_hi_s &&
                      ((cmd_lo_s == ARITH_MUL_INC) || (cmd_lo_s == ARITH_MUL_SHL));

    // Widened, sign-extended and rotated operand views shared by the commands
    always_comb begin
        ax_s      = {1'b0, opa_i};
        bx_s      = {1'b0, opb_i};
        sax_s     = {opa_i[width-1], opa_i};
        sbx_s     = {opb_i[width-1], opb_i};
        one_x_s   = {{width{1'b0}}, 1'b1};
        cin_x_s   = {{width{1'b0}}, cin_i};
        shl_a_s   = {opa_i[width-2:0], 1'b0};
        amt_s     = opb_i[RW-1:0];
        rot_bad_s = (opb_i >> RW) != '0;
        // A shift by the full width yields zero, so amount 0 rotates cleanly.
        rol_s     = (opa_i << amt_s) | (opa_i >> (width - int'(amt_s)));
        ror_s     = (opa_i >> amt_s) | (opa_i << (width - int'(amt_s)));
    end

    // Command decode: raw result, raw flags and the operands each command needs
    always_comb begin
        tmp_s       = '0;
        lres_s      = '0;
        res_raw_s   = '0;
        flags_raw_s = '0;
        need_s      = VLD_AB;
        defined_s   = 1'b1;
        rot_cmd_s   = 1'b0;
        if (cmd_hi_s) begin
            defined_s = 1'b0;
        end else if (mode_i) begin
            case (cmd_lo_s)
                ARITH_ADD: begin
                    tmp_s            = ax_s + bx_s;
                    res_raw_s        = W2'(tmp_s);
                    flags_raw_s.cout = tmp_s[width];
                end
                ARITH_SUB: begin
                    tmp_s             = ax_s - bx_s;
                    res_raw_s         = W2'(tmp_s);
                    flags_raw_s.oflow = (opa_i < opb_i);
                end
                ARITH_ADD_CIN: begin
                    tmp_s            = ax_s + bx_s + cin_x_s;
                    res_raw_s        = W2'(tmp_s);
                    flags_raw_s.cout = tmp_s[width];
                end
                ARITH_SUB_CIN: begin
                    tmp_s             = ax_s - bx_s - cin_x_s;
                    res_raw_s         = W2'(tmp_s);
                    flags_raw_s.oflow = (ax_s < (bx_s + cin_x_s));
                end
                ARITH_INC_A: begin
                    tmp_s     = ax_s + one_x_s;
                    res_raw_s = W2'(tmp_s);
                    need_s    = VLD_A;
                end
                ARITH_DEC_A: begin
                    tmp_s     = ax_s - one_x_s;
                    res_raw_s = W2'(tmp_s);
                    need_s    = VLD_A;
                end
                ARITH_INC_B: begin
                    tmp_s     = bx_s + one_x_s;
                    res_raw_s = W2'(tmp_s);
                    need_s    = VLD_B;
                end
                ARITH_DEC_B: begin
                    tmp_s     = bx_s - one_x_s;
                    res_raw_s = W2'(tmp_s);
                    need_s    = VLD_B;
                end
                ARITH_CMP: begin
                    flags_raw_s.g = (opa_i > opb_i);
                    flags_raw_s.e = (opa_i == opb_i);
                    flags_raw_s.l = (opa_i < opb_i);
                end
                ARITH_MUL_INC: begin
                    res_raw_s = W2'(ax_s + one_x_s) * W2'(bx_s + one_x_s);
                end
                ARITH_MUL_SHL: begin
                    res_raw_s = W2'(shl_a_s) * W2'(opb_i);
                end
                ARITH_SADD: begin
                    tmp_s             = sax_s + sbx_s;
                    res_raw_s         = W2'(tmp_s);
                    flags_raw_s.oflow = (opa_i[width-1] == opb_i[width-1]) &&
                                        (tmp_s[width-1] != opa_i[width-1]);
                    flags_raw_s.g     = ($signed(opa_i) >  $signed(opb_i));
                    flags_raw_s.e     = (opa_i == opb_i);
                    flags_raw_s.l     = ($signed(opa_i) <  $signed(opb_i));
                end
                ARITH_SSUB: begin
                    tmp_s             = sax_s - sbx_s;
                    res_raw_s         = W2'(tmp_s);
                    flags_raw_s.oflow = (opa_i[width-1] != opb_i[width-1]) &&
                                        (tmp_s[width-1] != opa_i[width-1]);
                    flags_raw_s.g     = ($signed(opa_i) >  $signed(opb_i));
                    flags_raw_s.e     = (opa_i == opb_i);
                    flags_raw_s.l     = ($signed(opa_i) <  $signed(opb_i));
                end
                default: begin
                    defined_s = 1'b0;
                end
            endcase
        end else begin
            case (cmd_lo_s)
                LOGIC_AND:     lres_s = opa_i & opb_i;
                LOGIC_NAND:    lres_s = ~(opa_i & opb_i);
                LOGIC_OR:      lres_s = opa_i | opb_i;
                LOGIC_NOR:     lres_s = ~(opa_i | opb_i);
                LOGIC_XOR:     lres_s = opa_i ^ opb_i;
                LOGIC_XNOR:    lres_s = ~(opa_i ^ opb_i);
                LOGIC_NOT_A: begin
                    lres_s = ~opa_i;
                    need_s = VLD_A;
                end
                LOGIC_NOT_B: begin
                    lres_s = ~opb_i;
                    need_s = VLD_B;
                end
                LOGIC_SHR1_A: begin
                    lres_s = {1'b0, opa_i[width-1:1]};
                    need_s = VLD_A;
                end
                LOGIC_SHL1_A: begin
                    lres_s = shl_a_s;
                    need_s = VLD_A;
                end
                LOGIC_SHR1_B: begin
                    lres_s = {1'b0, opb_i[width-1:1]};
                    need_s = VLD_B;
                end
                LOGIC_SHL1_B: begin
                    lres_s = {opb_i[width-2:0], 1'b0};
                    need_s = VLD_B;
                end
                LOGIC_ROL_A_B: begin
                    lres_s    = rol_s;
                    rot_cmd_s = 1'b1;
                end
                LOGIC_ROR_A_B: begin
                    lres_s    = ror_s;
                    rot_cmd_s = 1'b1;
                end
                default: begin
                    defined_s = 1'b0;
                end
            endcase
            res_raw_s = W2'(lres_s);
        end
    end

    // Any fault replaces the result with zero and raises ERR alone.
    assign fault_s = !defined_s ||
                     ((inp_valid_i & need_s) != need_s) ||
                     (rot_cmd_s && rot_bad_s);

    // Final result selection between the raw result and the fault pattern
    always_comb begin
        res_o   = '0;
        flags_o = '0;
        if (fault_s) begin
            flags_o.err = 1'b1;
        end else begin
            res_o   = res_raw_s;
            flags_o = flags_raw_s;
        end
    end

endmodule

// File: rtl/alu_core.sv
// Registered two-operand ALU. Inputs are captured in an input stage, most
// commands retire one edge later; multiplies pass through an extra stage.
// When a multiply and a later non-multiply retire together, the
// non-multiply (issued later) owns the output register.
module alu_core
    import alu_pkg::*;
#(
    parameter int width     = 4,
    parameter int CMD_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [1:0]           INP_VALID,
    input  logic [width-1:0]     OPA,
    input  logic [width-1:0]     OPB,
    input  logic                 CIN,
    output logic [2*width-1:0]   RES,
    output logic                 COUT,
    output logic                 OFLOW,
    output logic                 G,
    output logic                 E,
    output logic                 L,
    output logic                 ERR
);

    // Input stage
    logic                 mode_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic [1:0]           vld_q;
    logic [width-1:0]     opa_q;
    logic [width-1:0]     opb_q;
    logic                 cin_q;

    // Multiply stage
    logic                 mul_vld_q;
    logic                 mul_vld_d;
    logic [2*width-1:0]   mul_res_q;
    logic [2*width-1:0]   mul_res_d;
    logic                 mul_err_q;
    logic                 mul_err_d;

    // Output stage
    logic [2*width-1:0]   res_q;
    logic [2*width-1:0]   res_d;
    alu_flags_t           flags_q;
    alu_flags_t           flags_d;

    // Compute results
    logic [2*width-1:0]   comp_res_s;
    alu_flags_t           comp_flags_s;
    logic                 is_mul_s;

    alu_compute #(
        .width     (width),
        .CMD_WIDTH (CMD_WIDTH)
    ) u_compute (
        .mode_i      (mode_q),
        .cmd_i       (cmd_q),
        .inp_valid_i (vld_q),
        .opa_i       (opa_q),
        .opb_i       (opb_q),
        .cin_i       (cin_q),
        .res_o       (comp_res_s),
        .flags_o     (comp_flags_s),
        .is_mul_o    (is_mul_s)
    );

    // Next state of the multiply stage: load when the input stage holds a multiply
    always_comb begin
        mul_vld_d = is_mul_s;
        mul_res_d = mul_res_q;
        mul_err_d = mul_err_q;
        if (is_mul_s) begin
            mul_res_d = comp_res_s;
            mul_err_d = comp_flags_s.err;
        end else begin
            mul_res_d = mul_res_q;
            mul_err_d = mul_err_q;
        end
    end

    // Next output: a non-multiply retires directly, else a pending multiply, else hold
    always_comb begin
        res_d   = res_q;
        flags_d = flags_q;
        if (!is_mul_s) begin
            res_d   = comp_res_s;
            flags_d = comp_flags_s;
        end else if (mul_vld_q) begin
            res_d       = mul_res_q;
            flags_d     = '0;
            flags_d.err = mul_err_q;
        end else begin
            res_d   = res_q;
            flags_d = flags_q;
        end
    end

    // Input stage capture
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_q <= 1'b0;
            cmd_q  <= '0;
            vld_q  <= 2'b00;
            opa_q  <= '0;
            opb_q  <= '0;
            cin_q  <= 1'b0;
        end else if (CE) begin
            mode_q <= MODE;
            cmd_q  <= CMD;
            vld_q  <= INP_VALID;
            opa_q  <= OPA;
            opb_q  <= OPB;
            cin_q  <= CIN;
        end
    end

    // Multiply stage; reset discards any product still in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mul_vld_q <= 1'b0;
            mul_res_q <= '0;
            mul_err_q <= 1'b0;
        end else if (CE) begin
            mul_vld_q <= mul_vld_d;
            mul_res_q <= mul_res_d;
            mul_err_q <= mul_err_d;
        end
    end

    // Output stage
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (CE) begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign RES   = res_q;
    assign COUT  = flags_q.cout;
    assign OFLOW = flags_q.oflow;
    assign G     = flags_q.g;
    assign E     = flags_q.e;
    assign L     = flags_q.l;
    assign ERR   = flags_q.err;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core with hand-computed expectations.
// Flag vectors are ordered {COUT, OFLOW, G, E, L, ERR}.
module tb_alu_core;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CE;
    logic       MODE;
    logic [3:0] CMD;
    logic [1:0] INP_VALID;
    logic [3:0] OPA;
    logic [3:0] OPB;
    logic       CIN;
    logic [7:0] RES;
    logic       COUT;
    logic       OFLOW;
    logic       G;
    logic       E;
    logic       L;
    logic       ERR;
    logic [5:0] flg;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_core #(.width(4), .CMD_WIDTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .MODE      (MODE),
        .CMD       (CMD),
        .INP_VALID (INP_VALID),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .E         (E),
        .L         (L),
        .ERR       (ERR)
    );

    assign flg = {COUT, OFLOW, G, E, L, ERR};

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_res, input logic [5:0] exp_flg);
        check_val({tag, "_res"}, {8'h00, RES}, {8'h00, exp_res});
        check_val({tag, "_flg"}, {10'h000, flg}, {10'h000, exp_flg});
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] v,
                         input logic [3:0] a, input logic [3:0] b, input logic ci);
        MODE      = m;
        CMD       = c;
        INP_VALID = v;
        OPA       = a;
        OPB       = b;
        CIN       = ci;
    endtask

    // Advance n rising edges and settle just past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic m, input logic [3:0] c,
                           input logic [1:0] v, input logic [3:0] a, input logic [3:0] b,
                           input logic ci, input logic [7:0] exp_res, input logic [5:0] exp_flg);
        drive(m, c, v, a, b, ci);
        step(2);
        check_out(tag, exp_res, exp_flg);
    endtask

    initial begin
        RST = 1'b0;
        CE  = 1'b1;
        drive(1'b0, 4'd0, 2'b00, 4'h0, 4'h0, 1'b0);
        #3;
        check_out("reset", 8'h00, 6'b000000);
        step(1);
        check_out("reset_held", 8'h00, 6'b000000);
        RST = 1'b1;

        // Arithmetic set
        run_vec("add",     1'b1, 4'd0,  2'b11, 4'hF, 4'h1, 1'b0, 8'h10, 6'b100000);
        run_vec("sub",     1'b1, 4'd1,  2'b11, 4'h3, 4'h5, 1'b0, 8'h1E, 6'b010000);
        run_vec("cmp_eq",  1'b1, 4'd8,  2'b11, 4'h5, 4'h5, 1'b0, 8'h00, 6'b000100);
        run_vec("cmp_gt",  1'b1, 4'd8,  2'b11, 4'h7, 4'h2, 1'b0, 8'h00, 6'b001000);
        run_vec("cmp_lt",  1'b1, 4'd8,  2'b11, 4'h2, 4'h7, 1'b0, 8'h00, 6'b000010);
        run_vec("add_cin", 1'b1, 4'd2,  2'b11, 4'h7, 4'h8, 1'b1, 8'h10, 6'b100000);
        run_vec("sub_cin", 1'b1, 4'd3,  2'b11, 4'h5, 4'h5, 1'b1, 8'h1F, 6'b010000);
        run_vec("dec_a",   1'b1, 4'd5,  2'b01, 4'h0, 4'hF, 1'b0, 8'h1F, 6'b000000);
        run_vec("inc_b",   1'b1, 4'd6,  2'b10, 4'h3, 4'hF, 1'b0, 8'h10, 6'b000000);
        run_vec("inc_a_nv",1'b1, 4'd4,  2'b10, 4'h3, 4'h3, 1'b0, 8'h00, 6'b000001);
        run_vec("sadd",    1'b1, 4'd11, 2'b11, 4'h7, 4'h1, 1'b0, 8'h08, 6'b011000);
        run_vec("ssub",    1'b1, 4'd12, 2'b11, 4'h8, 4'h1, 1'b0, 8'h17, 6'b010010);

        // Multiply takes one extra edge; output holds the ssub result meanwhile
        drive(1'b1, 4'd9, 2'b11, 4'h2, 4'h3, 1'b0);
        step(2);
        check_out("mul_wait", 8'h17, 6'b010010);
        step(1);
        check_out("mul_inc", 8'h0C, 6'b000000);

        // Following a held multiply, the new product lands three edges later
        drive(1'b1, 4'd10, 2'b11, 4'h5, 4'h3, 1'b0);
        step(3);
        check_out("mul_shl", 8'h1E, 6'b000000);

        // Multiply then add back to back: the later add wins the shared edge
        drive(1'b1, 4'd9, 2'b11, 4'h2, 4'h3, 1'b0);
        step(1);
        drive(1'b1, 4'd0, 2'b11, 4'h1, 4'h1, 1'b0);
        step(2);
        check_out("b2b_add", 8'h02, 6'b000000);

        // Reset while a multiply is pending
        drive(1'b1, 4'd9, 2'b11, 4'h2, 4'h3, 1'b0);
        step(2);
        check_out("pre_rst", 8'h02, 6'b000000);
        RST = 1'b0;
        #1;
        check_out("rst_async", 8'h00, 6'b000000);
        step(1);
        check_out("rst_mul_drop", 8'h00, 6'b000000);
        RST = 1'b1;

        run_vec("arith_undef", 1'b1, 4'd13, 2'b11, 4'h4, 4'h4, 1'b0, 8'h00, 6'b000001);

        // Logical set
        run_vec("rol",     1'b0, 4'd12, 2'b11, 4'b1001, 4'b0001, 1'b0, 8'h03, 6'b000000);
        run_vec("ror",     1'b0, 4'd13, 2'b11, 4'b1001, 4'b0001, 1'b0, 8'h0C, 6'b000000);
        run_vec("rol_bad", 1'b0, 4'd12, 2'b11, 4'b1001, 4'b0101, 1'b0, 8'h00, 6'b000001);
        run_vec("and_nv",  1'b0, 4'd0,  2'b01, 4'hF,    4'hF,    1'b0, 8'h00, 6'b000001);
        run_vec("not_a",   1'b0, 4'd6,  2'b01, 4'b1010, 4'h0,    1'b0, 8'h05, 6'b000000);
        run_vec("xor",     1'b0, 4'd4,  2'b11, 4'b1100, 4'b1010, 1'b0, 8'h06, 6'b000000);
        run_vec("shl1_b",  1'b0, 4'd11, 2'b10, 4'h0,    4'b1001, 1'b0, 8'h02, 6'b000000);
        run_vec("nand",    1'b0, 4'd1,  2'b11, 4'b1100, 4'b1010, 1'b0, 8'h07, 6'b000000);

        // Clock enable low: every stage holds while inputs wander
        CE = 1'b0;
        drive(1'b1, 4'd0, 2'b11, 4'hF, 4'hF, 1'b1);
        step(1);
        drive(1'b1, 4'd9, 2'b11, 4'h3, 4'h3, 1'b0);
        step(1);
        drive(1'b0, 4'd4, 2'b11, 4'h1, 4'h2, 1'b0);
        step(1);
        check_out("ce_hold", 8'h07, 6'b000000);
        CE = 1'b1;

        run_vec("logic_undef", 1'b0, 4'd15, 2'b11, 4'h3, 4'h3, 1'b0, 8'h00, 6'b000001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
